config_loader: RTL and testbench
================================

Name: config_loader

Overview:
- Upstream configuration stage for the fpga_cell shift chain.
- Accepts configuration bytes from the host-side byte interface over a valid/ready handshake.
- Serialises the bytes MSB-first onto the head of the cell chain and drives the chain's shift_enable and LUT write address.
- Stops after exactly CHAIN_BITS bits and then reports done.

Parameters:
- CELL_COUNT, 16, number of fpga_cell instances in the chain.
- BITS_PER_CELL, 65, configuration bits per cell: 64 LUT bits plus 1 output_select bit.
- CHAIN_BITS, CELL_COUNT*BITS_PER_CELL, total bits shifted per configuration; derived, not overridden.

Ports:
- shift_clock  input  1  configuration clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; returns the block to IDLE.
- start  input  1  single-cycle request to begin a configuration.
- data_in  input  8  configuration byte.
- data_valid  input  1  data_in valid.
- data_ready  output  1  loader can accept a byte this cycle.
- chain_out  output  1  serial bit driven into shift_in of the first cell.
- shift_enable  output  1  chain shift/write enable, common to all cells.
- cfg_addr  output  6  LUT address muxed onto cell inputs during configuration.
- chain_tail  input  1  shift_out of the last cell.
- busy  output  1  configuration in progress.
- done  output  1  configuration complete.
- readback_data  output  8  reassembled tail byte (optional feature).
- readback_valid  output  1  readback_data strobe (optional feature).

Behaviour:
- Reset (asynchronous): state=IDLE, bit_count=0, sreg=0, cell_bit=0.
  - All outputs 0: data_ready, chain_out, shift_enable, cfg_addr, busy, done, readback_*.
- Reset mid-configuration aborts immediately. shift_enable drops asynchronously and no further bits are shifted. A new start is required.
- States are IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - start=1 -> LOAD; bit_count and cell_bit clear to 0; done clears.
- LOAD:
  - data_ready=1.
  - data_valid&data_ready at edge N -> sreg<=data_in, shift_left<=min(8, CHAIN_BITS-bit_count), state SHIFT.
- SHIFT:
  - shift_enable=1 and chain_out=sreg[7] combinationally from state and sreg.
  - Each edge: sreg<<=1, bit_count++, shift_left--, cell_bit advances 0..BITS_PER_CELL-1 and wraps to 0.
  - When shift_left reaches 0: if bit_count==CHAIN_BITS -> DONE, else -> LOAD.
- cfg_addr = cell_bit[5:0] in SHIFT and 0 elsewhere. The bit at cell_bit=64 writes with cfg_addr=0; this is the output_select bit.
- Timing: a byte accepted at edge N is shifted on cycles N+1..N+8, and data_ready reasserts in cycle N+9. Throughput is one byte per 9 cycles.
- Final partial byte: when CHAIN_BITS mod 8 = k (k≠0), only the top k bits of the last byte are shifted. The low 8-k bits are discarded.
- DONE: busy=0, done=1, held until the next accepted start or reset. start in DONE -> LOAD as from IDLE.
- busy=1 in LOAD and SHIFT.
- start while busy is ignored.
- data_valid while data_ready=0 is ignored; the source must hold data_in until ready.
- data_valid and start together in IDLE: start is taken and the byte is not consumed. It is accepted in the following LOAD cycle if still valid.
- chain_tail is ignored unless the optional feature is compiled in.

Optional Feature:
- Macro: CONFIG_READBACK_EN.
- Defined:
  - Every SHIFT cycle samples chain_tail into an 8-bit readback register, MSB-first.
  - After 8 samples, readback_valid pulses 1 cycle with readback_data = the byte.
  - A final partial group of k samples is emitted left-aligned, zero-padded, when entering DONE.
  - The readback register clears on start.
- Undefined: readback_data=0, readback_valid=0, chain_tail unused, no readback logic synthesised.

Test Plan (CELL_COUNT=2 -> CHAIN_BITS=130, 17 bytes):
- Reset, then start; feed 0xA5 -> chain_out over 8 SHIFT cycles = 1,0,1,0,0,1,0,1; shift_enable high exactly 8 cycles; data_ready low for 8 cycles, then high.
- Feed 17 bytes of 0xFF continuously -> shift_enable high for 130 cycles total; the last byte shifts only 2 bits; done=1, busy=0 from the cycle after bit 130 onward.
- cfg_addr over a full configuration -> sequence 0..63, 0 (bit 64), then 0..63, 0 for the second cell; cfg_addr=0 whenever shift_enable=0.
- Assert reset during bit 40 -> shift_enable=0 in the same cycle, state IDLE; a subsequent start plus 17 bytes completes normally with 130 shifts.
- Pulse start while busy; hold data_valid with data_ready=0 -> no restart, no byte consumed, bit_count unaffected.
- With CONFIG_READBACK_EN, loopback chain_out to chain_tail -> readback_valid pulses 16 times with bytes matching the input, plus a final 0xC0 for last byte 0xFF.

Source files
------------

// File: rtl/config_loader_if.sv
// Host-side configuration byte interface for config_loader.
// The host (master) presents data_in with data_valid; the loader (slave)
// answers with data_ready. A byte transfers on a rising edge where both
// data_valid and data_ready are high.
interface config_loader_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface : config_loader_if

// File: rtl/config_loader.sv
// config_loader: upstream configuration stage for the fpga_cell shift chain.
// Accepts configuration bytes over a valid/ready handshake, serialises them
// MSB-first onto the head of the chain, and drives shift_enable and the LUT
// write address. Stops after exactly CHAIN_BITS bits and reports done.
//
// Optional feature, macro CONFIG_READBACK_EN: samples chain_tail on every
// shift cycle and reassembles it into bytes on readback_data/readback_valid.
// Without the macro, readback outputs are tied to 0 and chain_tail is unused.
module config_loader #(
  parameter int CELL_COUNT    = 16,
  parameter int BITS_PER_CELL = 65
) (
  input  logic                 shift_clock,
  input  logic                 reset,
  input  logic                 start,
  config_loader_if.slave       host,
  output logic                 chain_out,
  output logic                 shift_enable,
  output logic [5:0]           cfg_addr,
  input  logic                 chain_tail,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           readback_data,
  output logic                 readback_valid
);

  localparam int CHAIN_BITS = CELL_COUNT * BITS_PER_CELL;
  localparam int BCW        = $clog2(CHAIN_BITS + 1);
  localparam int CBW        = $clog2(BITS_PER_CELL);

  localparam logic [BCW-1:0] LAST_BIT  = BCW'(CHAIN_BITS);
  localparam logic [CBW-1:0] CELL_WRAP = CBW'(BITS_PER_CELL - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  state_e         state_q, state_d;
  logic [BCW-1:0] bit_count_q, bit_count_d;
  logic [CBW-1:0] cell_bit_q, cell_bit_d;
  logic [7:0]     sreg_q, sreg_d;
  logic [3:0]     shift_left_q, shift_left_d;
  logic [BCW-1:0] remaining;

  // Bits still owed to the chain; the last byte may carry fewer than 8.
  assign remaining = LAST_BIT - bit_count_q;

  // Next-state and datapath update for the load/shift sequencer.
  always_comb begin
    // NOTE: every _d starts from its held value so no path through the case leaves it unassigned.
    state_d      = state_q;
    bit_count_d  = bit_count_q;
    cell_bit_d   = cell_bit_q;
    sreg_d       = sreg_q;
    shift_left_d = shift_left_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = LOAD;
          bit_count_d = '0;
          cell_bit_d  = '0;
        end
      end
      LOAD: begin
        if (host.data_valid) begin
          sreg_d       = host.data_in;
          shift_left_d = (remaining >= BCW'(8)) ? 4'd8 : remaining[3:0];
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d       = {sreg_q[6:0], 1'b0};
        bit_count_d  = bit_count_q + BCW'(1);
        shift_left_d = shift_left_q - 4'd1;
        cell_bit_d   = (cell_bit_q == CELL_WRAP) ? '0 : cell_bit_q + CBW'(1);
        if (shift_left_q == 4'd1) begin
          state_d = (bit_count_d == LAST_BIT) ? DONE : LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any configuration in flight.
  always_ff @(posedge shift_clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_count_q  <= '0;
      cell_bit_q   <= '0;
      sreg_q       <= '0;
      shift_left_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q      <= state_d;
      bit_count_q  <= bit_count_d;
      cell_bit_q   <= cell_bit_d;
      sreg_q       <= sreg_d;
      shift_left_q <= shift_left_d;
    end
  end

  // Outputs decode directly from the state register, so reset clears them at once.
  assign host.data_ready = (state_q == LOAD);
  assign busy            = (state_q == LOAD) || (state_q == SHIFT);
  assign done            = (state_q == DONE);
  assign shift_enable    = (state_q == SHIFT);
  assign chain_out       = (state_q == SHIFT) && sreg_q[7];
  // cell_bit 64 (the output_select bit) folds onto address 0.
  assign cfg_addr        = (state_q == SHIFT) ? cell_bit_q[5:0] : 6'd0;

`ifdef CONFIG_READBACK_EN
  logic       start_take;
  logic [7:0] rb_sreg_q;
  logic [3:0] rb_cnt_q;
  logic [7:0] rb_data_q;
  logic       rb_valid_q;
  logic [7:0] rb_next;
  logic [3:0] rb_cnt_next;

  assign start_take  = ((state_q == IDLE) || (state_q == DONE)) && start;
  assign rb_next     = {rb_sreg_q[6:0], chain_tail};
  assign rb_cnt_next = rb_cnt_q + 4'd1;

  // Collect tail bits while shifting; emit full bytes, and the left-aligned remainder at the end.
  always_ff @(posedge shift_clock or posedge reset) begin
    if (reset) begin
      rb_sreg_q  <= '0;
      rb_cnt_q   <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_valid_q <= 1'b0;
      if (start_take) begin
        rb_sreg_q <= '0;
        rb_cnt_q  <= '0;
      end else if (state_q == SHIFT) begin
        if (rb_cnt_next == 4'd8) begin
          rb_data_q  <= rb_next;
          rb_valid_q <= 1'b1;
          rb_sreg_q  <= '0;
          rb_cnt_q   <= '0;
        end else if (state_d == DONE) begin
          rb_data_q  <= rb_next << (4'd8 - rb_cnt_next);
          rb_valid_q <= 1'b1;
          rb_sreg_q  <= '0;
          rb_cnt_q   <= '0;
        end else begin
          rb_sreg_q <= rb_next;
          rb_cnt_q  <= rb_cnt_next;
        end
      end
    end
  end

  assign readback_data  = rb_data_q;
  assign readback_valid = rb_valid_q;
`else
  logic unused_chain_tail;
  assign unused_chain_tail = chain_tail;
  assign readback_data     = 8'd0;
  assign readback_valid    = 1'b0;
`endif

endmodule : config_loader

// File: tb/tb_config_loader.sv
// Testbench for config_loader with CELL_COUNT=2 (130 chain bits, 17 bytes).
// chain_out is looped back to chain_tail. A transaction-level model (a queue
// of pending chain bits and a running bit total) predicts every output each
// cycle; directed checks pin the model with hand-computed values.
module tb_config_loader;
  localparam int CELL_COUNT    = 2;
  localparam int BITS_PER_CELL = 65;
  localparam int CHAIN_BITS    = CELL_COUNT * BITS_PER_CELL;

  logic       shift_clock = 1'b0;
  logic       reset;
  logic       start;
  logic       chain_tail;
  logic       chain_out, shift_enable, busy, done, readback_valid;
  logic [5:0] cfg_addr;
  logic [7:0] readback_data;

  config_loader_if host ();

  config_loader #(
    .CELL_COUNT   (CELL_COUNT),
    .BITS_PER_CELL(BITS_PER_CELL)
  ) dut (
    .shift_clock   (shift_clock),
    .reset         (reset),
    .start         (start),
    .host          (host),
    .chain_out     (chain_out),
    .shift_enable  (shift_enable),
    .cfg_addr      (cfg_addr),
    .chain_tail    (chain_tail),
    .busy          (busy),
    .done          (done),
    .readback_data (readback_data),
    .readback_valid(readback_valid)
  );

  assign chain_tail = chain_out;

  always #5 shift_clock = ~shift_clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_LOAD, M_SHIFT, M_DONE} mode_e;
  mode_e m_mode = M_IDLE;
  bit    m_bits[$];
  int    m_shifted = 0;
  int    m_rb_acc = 0, m_rb_n = 0, m_rb_data = 0;
  bit    m_rb_valid = 1'b0;
  int    bytes_taken = 0;

  // Monitor logs, cleared by the stimulus at the start of each scenario.
  int          se_count = 0;
  logic [31:0] co_bits = '0;
  logic [5:0]  cfg_log[$];
  logic [7:0]  rb_log[$];
  logic [7:0]  sent[$];

  task automatic model_reset();
    m_mode = M_IDLE;
    m_bits.delete();
    m_shifted  = 0;
    m_rb_acc   = 0;
    m_rb_n     = 0;
    m_rb_valid = 1'b0;
  endtask

  // Advance the model across the coming rising edge using the inputs now held.
  task automatic model_step();
    int take;
    bit b;
    m_rb_valid = 1'b0;
    case (m_mode)
      M_IDLE, M_DONE: begin
        if (start) begin
          m_mode    = M_LOAD;
          m_shifted = 0;
          m_rb_acc  = 0;
          m_rb_n    = 0;
        end
      end
      M_LOAD: begin
        if (host.data_valid) begin
          take = CHAIN_BITS - m_shifted;
          if (take > 8) take = 8;
          for (int i = 0; i < take; i++) m_bits.push_back(host.data_in[7-i]);
          bytes_taken++;
          m_mode = M_SHIFT;
        end
      end
      M_SHIFT: begin
        b = m_bits.pop_front();
        m_shifted++;
        m_rb_acc = ((m_rb_acc << 1) | int'(b)) & 255;
        m_rb_n++;
        if (m_rb_n == 8 || m_shifted == CHAIN_BITS) begin
          m_rb_valid = 1'b1;
          m_rb_data  = (m_rb_acc << (8 - m_rb_n)) & 255;
          m_rb_acc   = 0;
          m_rb_n     = 0;
        end
        if (m_bits.size() == 0) m_mode = (m_shifted == CHAIN_BITS) ? M_DONE : M_LOAD;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  // Compare process: on every falling edge check outputs, log, then advance the model.
  initial begin
    forever begin
      @(negedge shift_clock);
      if (reset) model_reset();
      check("data_ready", host.data_ready, 32'(m_mode == M_LOAD));
      check("busy", busy, 32'(m_mode == M_LOAD || m_mode == M_SHIFT));
      check("done", done, 32'(m_mode == M_DONE));
      check("shift_enable", shift_enable, 32'(m_mode == M_SHIFT));
      check("chain_out", chain_out, (m_mode == M_SHIFT) ? 32'(m_bits[0]) : 32'd0);
      check("cfg_addr", cfg_addr,
            (m_mode == M_SHIFT) ? 32'((m_shifted % BITS_PER_CELL) % 64) : 32'd0);
`ifdef CONFIG_READBACK_EN
      check("readback_valid", readback_valid, 32'(m_rb_valid));
      if (m_rb_valid) check("readback_data", readback_data, 32'(m_rb_data));
`else
      check("readback_valid_off", readback_valid, 32'd0);
      check("readback_data_off", readback_data, 32'd0);
`endif
      if (shift_enable) begin
        se_count++;
        co_bits = {co_bits[30:0], chain_out};
        cfg_log.push_back(cfg_addr);
      end
      if (readback_valid) rb_log.push_back(readback_data);
      if (!reset) model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge shift_clock);
    #1;
  endtask

  task automatic clear_logs();
    se_count = 0;
    co_bits  = '0;
    cfg_log.delete();
    rb_log.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Present a byte after an idle gap and hold it until taken; optionally poke start while waiting.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    int n;
    host.data_valid = 1'b0;
    repeat (gap) tick();
    host.data_in    = b;
    host.data_valid = 1'b1;
    n = 0;
    while (!host.data_ready && n < 100) begin
      start = poke && ($urandom_range(0, 3) == 0);
      tick();
      start = 1'b0;
      n++;
    end
    check("byte_accept", host.data_ready, 32'd1);
    tick();
    host.data_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!host.data_ready && n < 50) begin
      tick();
      n++;
    end
  endtask

  // One complete configuration of 17 bytes, then pin the counts and addresses.
  task automatic run_config(input bit fixed, input logic [7:0] fbyte, input int gap_max,
                            input bit poke, input bit swv);
    int base, n, gap;
    sent.delete();
    for (int i = 0; i < 17; i++) sent.push_back(fixed ? fbyte : 8'($urandom));
    clear_logs();
    base = bytes_taken;
    if (swv) begin
      host.data_in    = sent[0];
      host.data_valid = 1'b1;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    if (swv) check("start_with_valid_not_consumed", 32'(bytes_taken - base), 32'd0);
    for (int i = 0; i < 17; i++) begin
      gap = (swv && i == 0) ? 0 : int'($urandom_range(0, gap_max));
      send_byte(sent[i], gap, poke);
    end
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check("done_reached", done, 32'd1);
    check("busy_after_done", busy, 32'd0);
    tick();
    check("done_held", done, 32'd1);
    check("shift_cycles", 32'(se_count), 32'd130);
    check("bytes_consumed", 32'(bytes_taken - base), 32'd17);
    check("cfg_log_size", 32'(cfg_log.size()), 32'd130);
    if (cfg_log.size() == 130) begin
      check("cfg_addr_bit0", cfg_log[0], 32'd0);
      check("cfg_addr_bit63", cfg_log[63], 32'd63);
      check("cfg_addr_bit64_select", cfg_log[64], 32'd0);
      check("cfg_addr_cell1_bit0", cfg_log[65], 32'd0);
      check("cfg_addr_cell1_bit63", cfg_log[128], 32'd63);
      check("cfg_addr_cell1_select", cfg_log[129], 32'd0);
    end
`ifdef CONFIG_READBACK_EN
    check("readback_count", 32'(rb_log.size()), 32'd17);
    if (rb_log.size() == 17) begin
      for (int i = 0; i < 16; i++) check("readback_byte", rb_log[i], sent[i]);
      check("readback_last_partial", rb_log[16], sent[16] & 8'hC0);
    end
`endif
  endtask

  initial begin
    int n;
    start           = 1'b0;
    host.data_in    = 8'd0;
    host.data_valid = 1'b0;
    reset           = 1'b0;
    #1 reset = 1'b1;
    tick();
    tick();
    check("reset_data_ready", host.data_ready, 32'd0);
    check("reset_busy", busy, 32'd0);
    check("reset_done", done, 32'd0);
    check("reset_shift_enable", shift_enable, 32'd0);
    check("reset_cfg_addr", cfg_addr, 32'd0);
    check("reset_chain_out", chain_out, 32'd0);
    reset = 1'b0;
    tick();

    // Single byte 0xA5: serial order, shift width and ready gap.
    start = 1'b1;
    tick();
    start = 1'b0;
    clear_logs();
    send_byte(8'hA5, 0, 1'b0);
    wait_ready(n);
    check("a5_ready_low_cycles", 32'(n), 32'd8);
    check("a5_serial_bits", co_bits[7:0], 32'hA5);
    check("a5_shift_cycles", 32'(se_count), 32'd8);
    check("a5_ready_back", host.data_ready, 32'd1);
    do_reset();

    // Full configuration of 0xFF, back-to-back bytes.
    run_config(1'b1, 8'hFF, 0, 1'b0, 1'b0);
    // Random bytes, restarted from DONE, with start pokes while busy and start+valid together.
    run_config(1'b0, 8'h00, 2, 1'b1, 1'b1);

    // Abort during bit 40, then a clean configuration.
    start = 1'b1;
    tick();
    start = 1'b0;
    clear_logs();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0, 1'b0);
    repeat (7) tick();
    check("abort_bits_before", 32'(se_count), 32'd39);
    check("abort_shifting", shift_enable, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_shift_enable", shift_enable, 32'd0);
    check("abort_busy", busy, 32'd0);
    check("abort_data_ready", host.data_ready, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("abort_idle_done", done, 32'd0);
    check("abort_idle_busy", busy, 32'd0);
    run_config(1'b0, 8'h00, 1, 1'b1, 1'b0);
    run_config(1'b0, 8'h00, 0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule : tb_config_loader
